// File: rtl/ps_request_fifo.sv
// Generic circular-buffer FIFO. The head entry is readable the cycle after it is written.
// A write is dropped while full (wr_rdy low). rd_rdy must only be asserted while rd_vld is high.
module ps_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  input  logic [WIDTH-1:0]           wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [WIDTH-1:0]           rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_fire;
  logic             rd_fire;

  assign wr_rdy  = (count != CNT_MAX);
  assign rd_vld  = (count != '0);
  assign wr_fire = wr_vld && wr_rdy;
  assign rd_fire = rd_rdy && rd_vld;
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_dat;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// Queues PS read/write requests and issues them one per cycle, capped at MAX_OUTSTANDING unanswered.
// Accept-to-valid is 2 cycles. req_ready falls only when the buffer is full, and the issue payload holds while *ready is low.
module ps_request_fifo #(
  parameter int DEPTH           = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  input  logic                                 req_write,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]                req_wdata,
  input  logic [DATA_WIDTH/8-1:0]              req_wstrb,
  output logic                                 req_ready,
  output logic                                 ps_arvalid,
  output logic [ADDR_WIDTH-1:0]                ps_araddr,
  input  logic                                 ps_arready,
  output logic                                 ps_wvalid,
  output logic [ADDR_WIDTH-1:0]                ps_awaddr,
  output logic [DATA_WIDTH-1:0]                ps_wdata,
  output logic [DATA_WIDTH/8-1:0]              ps_wstrb,
  input  logic                                 ps_wready,
  input  logic                                 rsp_done,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 rsp_err
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] OUT_ONE = OW'(1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         wstrb;
  } entry_t;
  localparam int EW = $bits(entry_t);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SLOT} state_t;

  state_t state;
  entry_t req_entry;
  entry_t head;
  logic   buf_rd_vld;
  logic   pop;
  logic   issue_hs;
  logic   slot_free;
  logic   slot_next;
  logic   rsp_dec;

  assign req_entry = {req_write, req_addr, req_wdata, req_wstrb};

  ps_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (req_valid),
    .wr_rdy (req_ready),
    .wr_dat (req_entry),
    .rd_vld (buf_rd_vld),
    .rd_rdy (pop),
    .rd_dat (head),
    .count  (count)
  );

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // Slot decisions use the registered outstanding; a same-cycle rsp_done only counts next cycle.
  assign issue_hs  = (ps_arvalid && ps_arready) || (ps_wvalid && ps_wready);
  assign slot_free = (outstanding < OUT_MAX);
  assign slot_next = (({1'b0, outstanding} + {1'b0, OUT_ONE}) < {1'b0, OUT_MAX});

  always_comb begin
    pop = 1'b0;
    unique case (state)
      IDLE:    pop = buf_rd_vld && slot_free;
      ISSUE:   pop = issue_hs && buf_rd_vld && slot_next;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ps_arvalid <= 1'b0;
      ps_wvalid  <= 1'b0;
      ps_araddr  <= '0;
      ps_awaddr  <= '0;
      ps_wdata   <= '0;
      ps_wstrb   <= '0;
    end else if (pop) begin
      state      <= ISSUE;
      ps_arvalid <= !head.write;
      ps_wvalid  <= head.write;
      if (head.write) begin
        ps_awaddr <= head.addr;
        ps_wdata  <= head.wdata;
        ps_wstrb  <= head.wstrb;
      end else begin
        ps_araddr <= head.addr;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (buf_rd_vld) state <= WAIT_SLOT;
        end
        ISSUE: begin
          if (issue_hs) begin
            state      <= IDLE;
            ps_arvalid <= 1'b0;
            ps_wvalid  <= 1'b0;
          end
        end
        WAIT_SLOT: begin
          if (slot_free) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A response with nothing outstanding is dropped and flagged until reset.
  assign rsp_dec = rsp_done && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      rsp_err     <= 1'b0;
    end else begin
      if (issue_hs && !rsp_dec)      outstanding <= outstanding + OUT_ONE;
      else if (!issue_hs && rsp_dec) outstanding <= outstanding - OUT_ONE;
      if (rsp_done && (outstanding == '0)) rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ps_request_fifo.sv
// Bench for ps_request_fifo: vector table plus multi-cycle corner sequences, issue scoreboard.
module tb_ps_request_fifo;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wstrb = '0;
  logic          req_ready;
  logic          ps_arvalid;
  logic [AW-1:0] ps_araddr;
  logic          ps_arready = 1'b0;
  logic          ps_wvalid;
  logic [AW-1:0] ps_awaddr;
  logic [DW-1:0] ps_wdata;
  logic [SW-1:0] ps_wstrb;
  logic          ps_wready = 1'b0;
  logic          rsp_done = 1'b0;
  logic [4:0]    count;
  logic [2:0]    outstanding;
  logic          empty;
  logic          full;
  logic          rsp_err;

  ps_request_fifo #(
    .DEPTH(16), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .ps_arvalid(ps_arvalid), .ps_araddr(ps_araddr), .ps_arready(ps_arready),
    .ps_wvalid(ps_wvalid), .ps_awaddr(ps_awaddr), .ps_wdata(ps_wdata),
    .ps_wstrb(ps_wstrb), .ps_wready(ps_wready), .rsp_done(rsp_done),
    .count(count), .outstanding(outstanding), .empty(empty), .full(full),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } sb_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          exp_wvalid;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic [SW-1:0] exp_wstrb;
  } vec_t;

  sb_t sb[$];
  int  n_total = 0;
  int  n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic sb_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
    sb_t e;
    e.write = w; e.addr = a; e.data = d; e.strb = s;
    return e;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic push_req(input sb_t stim, input sb_t exp);
    int n = 0;
    req_valid = 1'b1; req_write = stim.write; req_addr = stim.addr;
    req_wdata = stim.data; req_wstrb = stim.strb;
    @(negedge clk);
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("push_accept", 64'(req_ready), 64'd1);
    else sb.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ps_arvalid || ps_wvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic bit idle_now();
    return sb.size() == 0 && outstanding == 3'd0 && count == 5'd0 && !ps_arvalid && !ps_wvalid;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    ps_arready = 1'b1;
    ps_wready  = 1'b1;
    while (!idle_now() && n < 300) begin
      @(posedge clk); #1;
      rsp_done = (outstanding != 3'd0);
      n++;
    end
    rsp_done = 1'b0;
    check(name, 64'(idle_now()), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && ((ps_arvalid && ps_arready) || (ps_wvalid && ps_wready))) begin
      sb_t e;
      check("one_valid", 64'(ps_arvalid && ps_wvalid), 64'd0);
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("issue_kind", 64'(ps_wvalid), 64'(e.write));
        if (ps_wvalid) begin
          check("awaddr", 64'(ps_awaddr), 64'(e.addr));
          check("wdata", 64'(ps_wdata), 64'(e.data));
          check("wstrb", 64'(ps_wstrb), 64'(e.strb));
        end else begin
          check("araddr", 64'(ps_araddr), 64'(e.addr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[8];
    bit   ok;
    int   hs;
    int   run;
    int   maxrun;
    sb_t  e;

    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, 32'h0000_0000, 32'h0, 4'h0};
    vecs[1] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF};
    vecs[2] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'h0, 1'b1, 32'h0000_0040, 32'h1234_5678, 4'h0};
    vecs[3] = '{1'b0, 32'hDEAD_BEE0, 32'h5555_5555, 4'h3, 1'b0, 32'hDEAD_BEE0, 32'h5555_5555, 4'h3};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'hA5A5_5A5A, 4'h9, 1'b1, 32'h8000_0000, 32'hA5A5_5A5A, 4'h9};
    vecs[5] = '{1'b0, 32'h0000_0004, 32'h0, 4'h0, 1'b0, 32'h0000_0004, 32'h0, 4'h0};
    vecs[6] = '{1'b1, 32'h0001_0000, 32'h0000_0001, 4'h1, 1'b1, 32'h0001_0000, 32'h0000_0001, 4'h1};
    vecs[7] = '{1'b0, 32'h7FFF_FFFF, 32'h0, 4'h0, 1'b0, 32'h7FFF_FFFF, 32'h0, 4'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_arvalid", 64'(ps_arvalid), 64'd0);
    check("rst_wvalid", 64'(ps_wvalid), 64'd0);
    check("rst_araddr", 64'(ps_araddr), 64'd0);
    check("rst_awaddr", 64'(ps_awaddr), 64'd0);

    // Single read latency and outstanding tracking
    @(posedge clk); #1;
    ps_arready = 1'b1; ps_wready = 1'b1;
    push_req(mk(1'b0, 32'h100, 32'h0, 4'h0), mk(1'b0, 32'h100, 32'h0, 4'h0));
    @(negedge clk);
    check("lat_t1_arvalid", 64'(ps_arvalid), 64'd0);
    @(negedge clk);
    check("lat_t2_arvalid", 64'(ps_arvalid), 64'd1);
    check("lat_t2_araddr", 64'(ps_araddr), 64'h100);
    @(negedge clk);
    check("lat_t3_arvalid", 64'(ps_arvalid), 64'd0);
    check("lat_outstanding", 64'(outstanding), 64'd1);
    @(posedge clk); #1 rsp_done = 1'b1;
    @(posedge clk); #1 rsp_done = 1'b0;
    @(negedge clk);
    check("lat_outstanding_done", 64'(outstanding), 64'd0);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      e = mk(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      push_req(e, mk(vecs[i].exp_wvalid, vecs[i].exp_addr, vecs[i].exp_wdata, vecs[i].exp_wstrb));
      wait_valid(10, ok);
      check("vec_issue", 64'(ok), 64'd1);
      check("vec_wvalid", 64'(ps_wvalid), 64'(vecs[i].exp_wvalid));
      check("vec_arvalid", 64'(ps_arvalid), 64'(!vecs[i].exp_wvalid));
      @(negedge clk);
      check("vec_outstanding", 64'(outstanding), 64'd1);
      @(posedge clk); #1 rsp_done = 1'b1;
      @(posedge clk); #1 rsp_done = 1'b0;
      @(negedge clk);
      check("vec_outstanding_done", 64'(outstanding), 64'd0);
    end

    // Fill to full with writes stalled, overflow attempt, then drain across the wrap
    @(posedge clk); #1 ps_wready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      e = mk(1'b1, 32'h1000 + 32'(i * 4), 32'hA5A5_0000 | 32'(i), 4'(i));
      push_req(e, e);
      if (i == 15) begin
        @(negedge clk);
        check("fill15_count", 64'(count), 64'd15);
        check("fill15_full", 64'(full), 64'd0);
        check("fill15_ready", 64'(req_ready), 64'd1);
        check("fill15_wvalid", 64'(ps_wvalid), 64'd1);
        check("fill15_awaddr", 64'(ps_awaddr), 64'h1000);
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("full_count", 64'(count), 64'd16);
    check("full_flag", 64'(full), 64'd1);
    check("full_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hDEAD_0000; req_wdata = 32'hBAD; req_wstrb = 4'hF;
    @(negedge clk);
    check("push18_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("push18_count", 64'(count), 64'd16);
    drain("drain_full");

    // Outstanding limit: four back-to-back, then wait for a slot
    @(posedge clk); #1 ps_arready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = mk(1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'h0);
      push_req(e, e);
    end
    @(negedge clk);
    check("lim_count_queued", 64'(count), 64'd5);
    @(posedge clk); #1 ps_arready = 1'b1;
    hs = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ps_arvalid) begin
        hs++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
    check("lim_issued", 64'(hs), 64'd4);
    check("lim_back_to_back", 64'(maxrun), 64'd4);
    check("lim_outstanding", 64'(outstanding), 64'd4);
    check("lim_count", 64'(count), 64'd2);
    @(posedge clk); #1 rsp_done = 1'b1;
    @(posedge clk); #1 rsp_done = 1'b0;
    wait_valid(6, ok);
    check("lim_fifth_issue", 64'(ok && ps_arvalid), 64'd1);
    check("lim_fifth_count", 64'(count), 64'd1);
    drain("drain_limit");

    // Write payload held stable under backpressure
    @(posedge clk); #1 ps_wready = 1'b0;
    e = mk(1'b1, 32'h5000, 32'hCAFE_F00D, 4'b1010);
    push_req(e, e);
    wait_valid(6, ok);
    check("stall_issue", 64'(ok), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall_wvalid", 64'(ps_wvalid), 64'd1);
      check("stall_awaddr", 64'(ps_awaddr), 64'h5000);
      check("stall_wdata", 64'(ps_wdata), 64'hCAFE_F00D);
      check("stall_wstrb", 64'(ps_wstrb), 64'b1010);
      @(negedge clk);
    end
    drain("drain_stall");

    // Spurious response
    @(posedge clk); #1 rsp_done = 1'b1;
    @(posedge clk); #1 rsp_done = 1'b0;
    @(negedge clk);
    check("err_outstanding", 64'(outstanding), 64'd0);
    check("err_flag", 64'(rsp_err), 64'd1);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(rsp_err), 64'd1);

    // Reset mid-operation
    @(posedge clk); #1 ps_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = mk(1'b0, 32'h3000 + 32'(i * 4), 32'h0, 4'h0);
      push_req(e, e);
    end
    @(negedge clk);
    check("mid_arvalid", 64'(ps_arvalid), 64'd1);
    check("mid_count", 64'(count), 64'd3);
    @(posedge clk); #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_arvalid", 64'(ps_arvalid), 64'd0);
    check("mrst_araddr", 64'(ps_araddr), 64'd0);
    check("mrst_count", 64'(count), 64'd0);
    check("mrst_outstanding", 64'(outstanding), 64'd0);
    check("mrst_ready", 64'(req_ready), 64'd1);
    check("mrst_rsp_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1 ps_arready = 1'b1;
    e = mk(1'b0, 32'h4444, 32'h0, 4'h0);
    push_req(e, e);
    @(negedge clk);
    check("mrst_t1_arvalid", 64'(ps_arvalid), 64'd0);
    @(negedge clk);
    check("mrst_t2_arvalid", 64'(ps_arvalid), 64'd1);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
